// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : EX-stage multi-cycle restoring divider, signed or unsigned,
//            one quotient bit per cycle; stalls the pipeline while busy.
// Revision : 1.0
// ============================================================================
module div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             stallreq
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_byzero = 2'd1;
  localparam logic [1:0] c_on     = 2'd2;
  localparam logic [1:0] c_end    = 2'd3;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;   // dividend magnitude, becomes the quotient as bits shift in
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_raw;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_ready;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_part_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;
  logic [WIDTH-1:0] w_quot_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic             w_abort;

  assign w_dvd_mag = (signed_div & dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag = (signed_div & divisor[WIDTH-1])  ? -divisor  : divisor;

  // Partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign w_trial    = {r_part, r_dvd[WIDTH-1]};
  assign w_diff     = w_trial - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_part_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_dvd_nxt  = {r_dvd[WIDTH-2:0], w_qbit};

  assign w_quot_fin = r_neg_q ? -w_dvd_nxt  : w_dvd_nxt;
  assign w_rem_fin  = r_neg_r ? -w_part_nxt : w_part_nxt;

  assign w_abort = annul | ~start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_part  <= '0;
      r_raw   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          r_ready <= 1'b0;
          if (start && !annul) begin
            r_raw <= dividend;
            if (divisor == '0) begin
              r_state <= c_byzero;
            end else begin
              r_state <= c_on;
              r_dvd   <= w_dvd_mag;
              r_dvs   <= w_dvs_mag;
              r_neg_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg_r <= signed_div & dividend[WIDTH-1];
              r_part  <= '0;
              r_cnt   <= '0;
            end
          end
        end
        c_byzero: begin
          if (w_abort) begin
            r_state <= c_idle;
          end else begin
            r_state <= c_end;
            r_ready <= 1'b1;
            r_quot  <= {WIDTH{1'b1}};
            r_rem   <= r_raw;
          end
        end
        c_on: begin
          // Annul wins even on the final iteration.
          if (w_abort) begin
            r_state <= c_idle;
            r_ready <= 1'b0;
          end else begin
            r_part <= w_part_nxt;
            r_dvd  <= w_dvd_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
              r_quot  <= w_quot_fin;
              r_rem   <= w_rem_fin;
              r_ready <= 1'b1;
              r_state <= c_end;
            end
          end
        end
        c_end: begin
          if (w_abort) begin
            r_state <= c_idle;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= c_idle;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign ready     = r_ready;
  assign stallreq  = start & ~r_ready;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Scoreboard bench for div_unit with directed divide vectors.
// Revision : 1.0
// ============================================================================
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic        signed_div = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ready;
  logic        stallreq;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  div_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .annul(annul),
    .signed_div(signed_div), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .ready(ready),
    .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each newly presented result against the oldest expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready && !prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got q=%0h r=%0h expected none", quotient, remainder);
        end else begin
          e = sb.pop_front();
          if (quotient !== e.q || remainder !== e.r) begin
            errors++;
            $display("FAIL result: got q=%0h r=%0h expected q=%0h r=%0h",
                     quotient, remainder, e.q, e.r);
          end
        end
      end
      prev = ready;
    end
  end

  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                         input logic [15:0] eq, input logic [15:0] er, input int lat);
    int n;
    int hi;
    bit done;
    sb.push_back('{q: eq, r: er});
    @(negedge clk);
    dividend = a; divisor = b; signed_div = sgn; annul = 1'b0; start = 1'b1;
    n = 0; hi = 0; done = 1'b0;
    #1;
    while (!done && n < 40) begin
      if (stallreq) hi++;
      @(posedge clk);
      n++;
      #1;
      if (ready) done = 1'b1;
    end
    check("latency", n, lat);
    check("stall_cycles", hi, lat);
    check("stall_low_at_ready", {31'b0, stallreq}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("ready_drop", {31'b0, ready}, 32'd0);
    check("quot_hold", {16'b0, quotient}, {16'b0, eq});
  endtask

  initial begin
    // Reset state, and stallreq tracking start while ready is low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_quot", {16'b0, quotient}, 32'd0);
    check("rst_rem", {16'b0, remainder}, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_stall_idle", {31'b0, stallreq}, 32'd0);
    @(negedge clk);
    start = 1'b1;
    #1;
    check("rst_stall_follows_start", {31'b0, stallreq}, 32'd1);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;

    run_div(16'd100, 16'd7, 1'b0, 16'h000E, 16'h0002, 17);
    run_div(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 17);
    run_div(16'hFFF9, 16'h0002, 1'b0, 16'h7FFC, 16'h0001, 17);
    run_div(16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 2);

    // Annul mid-flight: outputs keep the divide-by-zero result.
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd3; signed_div = 1'b0; start = 1'b1;
    repeat (8) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul_ready", {31'b0, ready}, 32'd0);
    check("annul_quot_hold", {16'b0, quotient}, 32'h0000FFFF);
    check("annul_rem_hold", {16'b0, remainder}, 32'h00001234);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    check("annul_no_late_ready", {31'b0, ready}, 32'd0);
    run_div(16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 17);

    // Reset during an in-flight divide.
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd3; signed_div = 1'b0; start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_quot", {16'b0, quotient}, 32'd0);
    check("midrst_rem", {16'b0, remainder}, 32'd0);
    check("midrst_ready", {31'b0, ready}, 32'd0);
    check("midrst_stall", {31'b0, stallreq}, 32'd1);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    run_div(16'd65535, 16'd255, 1'b0, 16'd257, 16'd0, 17);

    run_div(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 17);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider in the EX stage of the 16-bit 5-stage pipeline.
- Performs restoring division, one quotient bit per cycle, signed or unsigned.
- Its stallreq output drives the stall controller's stallreq_from_ex input. That freezes PC, IF/ID, ID/EX and EX while a divide is in flight, so start and the operands stay stable until the result is ready.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  divide request from EX; held high until ready is seen
- annul  input  1  cancel request (flush); aborts any in-flight divide
- signed_div  input  1  1 = two's-complement divide, 0 = unsigned
- dividend  input  WIDTH  opdata1
- divisor  input  WIDTH  opdata2
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- ready  output  1  registered; result valid
- stallreq  output  1  combinational; equals start & ~ready

Behaviour:
- Reset (rst=1 at clock edge, any state):
  - state=IDLE, ready=0, quotient=0, remainder=0, counter=0.
  - Internal dividend/divisor registers cleared.
  - stallreq follows start, since ready=0.
- States: IDLE, BYZERO, ON, END. Two-bit encoding, free choice.
- IDLE:
  - If start=1 and annul=0 and divisor==0 → BYZERO.
  - If start=1 and annul=0 and divisor!=0 → ON. At the same edge, latch operand magnitudes: two's-complement absolute value if signed_div=1 and MSB=1, else raw.
  - Also latch neg_q = signed_div & (dividend[MSB]^divisor[MSB]), neg_r = signed_div & dividend[MSB], and the raw dividend. Partial remainder=0, counter=0.
  - Otherwise stay in IDLE.
- BYZERO:
  - If annul=1 or start=0 → IDLE.
  - Else → END with ready=1, quotient={WIDTH{1'b1}}, remainder=raw dividend.
- ON, each cycle with annul=0 and start=1:
  - Shift {partial, dividend_reg} left 1.
  - Trial-subtract the divisor from the upper half.
  - If the difference is non-negative (no borrow), keep it and shift in quotient bit 1; else restore and shift in 0.
  - counter+1.
- ON, final iteration (counter==WIDTH-1):
  - Load outputs with sign correction: quotient negated if neg_q, remainder negated if neg_r.
  - ready=1, → END.
- ON, annul=1 or start=0 → IDLE, ready=0, outputs unchanged. Annul has priority over iteration completion in the same cycle.
- END:
  - Hold outputs and ready=1 while start=1.
  - start=0 → IDLE, ready=0, outputs hold their last value.
  - annul=1 → IDLE, ready=0.
- Latency, non-zero divisor: start sampled at edge 0, ready=1 after edge WIDTH+1 (17 edges for WIDTH=16).
  - stallreq is high for exactly WIDTH+1 cycles, then low in the cycle ready is first seen.
- Latency, divide by zero: ready=1 after edge 2.
- Overflow: signed −2^(WIDTH−1) / −1 gives quotient 0x8000 (wraps) and remainder 0. No trap, no flag.
- Back-to-back divides: a new divide cannot start in the END cycle. start must drop for one cycle (IDLE) before the next request is accepted.
- Arithmetic: the trial subtract is WIDTH+1 bits wide so the borrow is visible. All negations are modulo 2^WIDTH.

Test Plan:
- Unsigned 100/7 (signed_div=0):
  - quotient=14 (0x000E), remainder=2.
  - ready rises after edge 17; stallreq high cycles 0–16, low at cycle 17.
- Signed −7/2 (0xFFF9/0x0002, signed_div=1):
  - quotient=0xFFFD (−3), remainder=0xFFFF (−1).
  - Unsigned run of the same operands gives quotient=0x7FFC, remainder=1.
- Divide by zero, 0x1234/0:
  - ready after edge 2, quotient=0xFFFF, remainder=0x1234, state never enters ON.
- annul pulsed at cycle 8 of an ON run:
  - Next cycle state=IDLE, ready=0, outputs hold the prior result.
  - A fresh 50/5 then completes with quotient=10, remainder=0.
- rst asserted at cycle 5 of a divide:
  - After the edge all outputs are 0, ready=0, state=IDLE.
  - The following divide 65535/255 (unsigned) gives quotient=257, remainder=0.
- Signed 0x8000/0xFFFF:
  - quotient=0x8000, remainder=0.
  - After start drops, ready returns to 0 at the next edge.
